// File: rtl/core_pkg.sv
// Shared rename-stage constants for the physical-register free list.
//   PREGS     : physical register count
//   ARCH_REGS : pregs 0..ARCH_REGS-1 hold the reset architectural mapping
//   ALLOC_W   : default allocation lanes per cycle
//   FREE_W    : default release lanes per cycle
package core_pkg;

    localparam int unsigned PREGS     = 64;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PREG_W    = $clog2(PREGS);
    localparam int unsigned ALLOC_W   = 2;
    localparam int unsigned FREE_W    = 2;

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/free_list_picker.sv
// Finds the N lowest set bits of a mask, in ascending order.
//   i_mask    : candidate bitmap
//   o_idx_c   : index of the k-th lowest set bit in slot k
//   o_valid_c : slot k holds a real index
module free_list_picker
    import core_pkg::*;
#(
    parameter int unsigned WIDTH = PREGS,
    parameter int unsigned N     = ALLOC_W,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]          i_mask,
    output logic [N-1:0][IDX_W-1:0]   o_idx_c,
    output logic [N-1:0]              o_valid_c
);

    // Ascending scan; each set bit lands in the slot equal to the number of set bits below it.
    always_comb begin
        int unsigned cnt;
        o_idx_c   = '0;
        o_valid_c = '0;
        cnt       = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_mask[i]) begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (cnt == k) begin
                        o_idx_c[k]   = IDX_W'(i);
                        o_valid_c[k] = 1'b1;
                    end
                end
                cnt = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/multi_free_list.sv
// Multi-lane physical-register free list with all-or-nothing allocation,
// multi-lane release, illegal-release detection and checkpoint restore.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_alloc_req        : per-lane allocation request
//   o_alloc_ok_c       : enough free pregs for every requesting lane (comb)
//   o_alloc_phys_c     : preg granted per lane (comb)
//   i_free_en/phys     : per-lane release
//   i_restore_en/mask  : load free mask from a rename checkpoint
//   o_free_count       : number of free pregs
//   o_dbl_free_err     : one-cycle pulse on an illegal release
module multi_free_list
    import core_pkg::*;
#(
    parameter int unsigned PHYS_REGS = core_pkg::PREGS,
    parameter int unsigned ARCH_REGS = core_pkg::ARCH_REGS,
    parameter int unsigned ALLOC_W   = core_pkg::ALLOC_W,
    parameter int unsigned FREE_W    = core_pkg::FREE_W,
    parameter int unsigned PREG_W    = $clog2(PHYS_REGS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [ALLOC_W-1:0]               i_alloc_req,
    output logic                             o_alloc_ok_c,
    output logic [ALLOC_W-1:0][PREG_W-1:0]   o_alloc_phys_c,
    input  logic [FREE_W-1:0]                i_free_en,
    input  logic [FREE_W-1:0][PREG_W-1:0]    i_free_phys,
    input  logic                             i_restore_en,
    input  logic [PHYS_REGS-1:0]             i_restore_mask,
    output logic [PREG_W:0]                  o_free_count,
    output logic                             o_dbl_free_err
);

    localparam int unsigned CNT_W = PREG_W + 1;
    localparam logic [PHYS_REGS-1:0] RST_MASK  = {PHYS_REGS{1'b1}} << ARCH_REGS;
    localparam logic [CNT_W-1:0]     RST_COUNT = CNT_W'(PHYS_REGS - ARCH_REGS);

    logic [PHYS_REGS-1:0]            r_free_mask;
    logic [PHYS_REGS-1:0]            r_was_alloc;
    logic [CNT_W-1:0]                r_free_count;
    logic                            r_dbl_free_err;

    logic [ALLOC_W-1:0][PREG_W-1:0]  w_pick_idx;
    logic [ALLOC_W-1:0]              w_pick_valid;
    logic                            w_alloc_ok;
    logic [ALLOC_W-1:0][PREG_W-1:0]  w_alloc_phys;
    logic [PHYS_REGS-1:0]            w_alloc_clr;
    logic [PHYS_REGS-1:0]            w_rel_set;
    logic                            w_dbl_err;
    logic [PHYS_REGS-1:0]            w_mask_nxt;
    logic [CNT_W-1:0]                w_count_nxt;

    free_list_picker #(
        .WIDTH (PHYS_REGS),
        .N     (ALLOC_W),
        .IDX_W (PREG_W)
    ) u_picker (
        .i_mask    (r_free_mask),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    // Grant, release and next-state computation.
    always_comb begin
        int unsigned req_cnt;
        int unsigned rank;
        int unsigned cnt_nxt;
        logic [PHYS_REGS-1:0] rel;

        req_cnt      = 0;
        rank         = 0;
        cnt_nxt      = 0;
        rel          = '0;
        w_alloc_phys = '0;
        w_alloc_clr  = '0;
        w_dbl_err    = 1'b0;

        for (int unsigned j = 0; j < ALLOC_W; j++) begin
            if (i_alloc_req[j]) req_cnt = req_cnt + 1;
        end
        // Restore owns the cycle, so allocation is suppressed.
        w_alloc_ok = !i_restore_en && (32'(r_free_count) >= req_cnt);

        // Lane j takes the pick slot equal to the number of requesting lanes below it.
        for (int unsigned j = 0; j < ALLOC_W; j++) begin
            for (int unsigned k = 0; k < ALLOC_W; k++) begin
                if (rank == k) begin
                    w_alloc_phys[j] = w_pick_idx[k];
                    if (i_alloc_req[j] && w_alloc_ok && w_pick_valid[k])
                        w_alloc_clr = w_alloc_clr | (PHYS_REGS'(1) << w_pick_idx[k]);
                end
            end
            if (i_alloc_req[j]) rank = rank + 1;
        end

        // Illegal: already free, a never-allocated reset mapping, or a duplicate lane.
        for (int unsigned f = 0; f < FREE_W; f++) begin
            if (i_free_en[f]) begin
                if (r_free_mask[i_free_phys[f]] || !r_was_alloc[i_free_phys[f]] ||
                    rel[i_free_phys[f]])
                    w_dbl_err = 1'b1;
                rel[i_free_phys[f]] = 1'b1;
            end
        end
        w_rel_set = rel;

        if (i_restore_en)
            w_mask_nxt = i_restore_mask | w_rel_set;
        else
            w_mask_nxt = (r_free_mask & ~w_alloc_clr) | w_rel_set;

        for (int unsigned i = 0; i < PHYS_REGS; i++) begin
            if (w_mask_nxt[i]) cnt_nxt = cnt_nxt + 1;
        end
        w_count_nxt = CNT_W'(cnt_nxt);
    end

    // State registers; r_was_alloc marks pregs that may legally be released while busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_free_mask    <= RST_MASK;
            r_was_alloc    <= RST_MASK;
            r_free_count   <= RST_COUNT;
            r_dbl_free_err <= 1'b0;
        end else begin
            r_free_mask    <= w_mask_nxt;
            r_was_alloc    <= r_was_alloc | w_alloc_clr;
            r_free_count   <= w_count_nxt;
            r_dbl_free_err <= w_dbl_err;
        end
    end

    assign o_alloc_ok_c   = w_alloc_ok;
    assign o_alloc_phys_c = w_alloc_phys;
    assign o_free_count   = r_free_count;
    assign o_dbl_free_err = r_dbl_free_err;

endmodule

// File: tb/tb_multi_free_list.sv
// Scoreboard bench for multi_free_list: a driver updates an array-based
// reference model and queues expectations; a monitor compares at each negedge.
module tb_multi_free_list;
    import core_pkg::*;

    localparam int unsigned NP = 64;
    localparam int unsigned NA = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned FW = 2;
    localparam int unsigned PW = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [AW-1:0]          alloc_req;
    logic                   alloc_ok;
    logic [AW-1:0][PW-1:0]  alloc_phys;
    logic [FW-1:0]          free_en;
    logic [FW-1:0][PW-1:0]  free_phys;
    logic                   restore_en;
    logic [NP-1:0]          restore_mask;
    logic [PW:0]            free_count;
    logic                   dbl_free_err;

    always #5 clk = ~clk;

    multi_free_list dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_alloc_req    (alloc_req),
        .o_alloc_ok_c   (alloc_ok),
        .o_alloc_phys_c (alloc_phys),
        .i_free_en      (free_en),
        .i_free_phys    (free_phys),
        .i_restore_en   (restore_en),
        .i_restore_mask (restore_mask),
        .o_free_count   (free_count),
        .o_dbl_free_err (dbl_free_err)
    );

    typedef struct {
        logic          ok;
        logic [AW-1:0] req;
        int            phys [AW];
        int            cnt;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: free[] is the architectural free set, owned[] marks
    // pregs that have been handed out (or were never part of the reset mapping).
    bit   m_free  [NP];
    bit   m_owned [NP];
    bit   m_err;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < NP; i++) c += m_free[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_free[i]  = (i >= NA);
            m_owned[i] = (i >= NA);
        end
        m_err = 1'b0;
    endtask

    // Called just after a rising edge: applies one cycle of stimulus, returns one cycle later.
    task automatic drive(input logic [AW-1:0] req, input logic [FW-1:0] fen,
                         input int f0, input int f1, input logic ren, input logic [NP-1:0] rmask);
        exp_t e;
        int   fl[$];
        int   fp [FW];
        int   take;
        bit   rel [NP];
        bit   nerr;

        alloc_req    = req;
        free_en      = fen;
        free_phys[0] = PW'(f0);
        free_phys[1] = PW'(f1);
        restore_en   = ren;
        restore_mask = rmask;
        fp[0] = f0;
        fp[1] = f1;

        for (int i = 0; i < NP; i++) if (m_free[i]) fl.push_back(i);
        e.req = req;
        e.cnt = fl.size();
        e.err = m_err;
        e.ok  = !ren && (fl.size() >= $countones(req));
        take  = 0;
        for (int l = 0; l < AW; l++) begin
            e.phys[l] = -1;
            if (req[l] && e.ok) begin
                e.phys[l] = fl[take];
                take++;
            end
        end
        q.push_back(e);

        nerr = 1'b0;
        for (int i = 0; i < NP; i++) rel[i] = 1'b0;
        for (int f = 0; f < FW; f++) begin
            if (fen[f]) begin
                if (m_free[fp[f]] || !m_owned[fp[f]] || rel[fp[f]]) nerr = 1'b1;
                rel[fp[f]] = 1'b1;
            end
        end
        for (int l = 0; l < AW; l++) begin
            if (e.phys[l] >= 0) begin
                m_free[e.phys[l]]  = 1'b0;
                m_owned[e.phys[l]] = 1'b1;
            end
        end
        if (ren) for (int i = 0; i < NP; i++) m_free[i] = rmask[i];
        for (int i = 0; i < NP; i++) if (rel[i]) m_free[i] = 1'b1;
        m_err = nerr;

        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req    = '0;
        free_en      = '0;
        free_phys    = '0;
        restore_en   = 1'b0;
        restore_mask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Random release lane: mostly a legally releasable busy preg, sometimes anything.
    function automatic int pick_release();
        int legal[$];
        for (int i = 0; i < NP; i++) if (!m_free[i] && m_owned[i]) legal.push_back(i);
        if (legal.size() > 0 && ($urandom % 8) != 0)
            return legal[$urandom_range(0, legal.size() - 1)];
        return int'($urandom_range(0, NP - 1));
    endfunction

    // Monitor: inputs change just after posedge, so negedge sees settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("alloc_ok", longint'(alloc_ok), longint'(e.ok));
                for (int l = 0; l < AW; l++)
                    if (e.phys[l] >= 0)
                        chk($sformatf("alloc_phys[%0d]", l), longint'(alloc_phys[l]), longint'(e.phys[l]));
                chk("free_count", longint'(free_count), longint'(e.cnt));
                chk("dbl_free_err", longint'(dbl_free_err), longint'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int f1;
        logic [FW-1:0] fen;
        logic [NP-1:0] rm;

        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // First grant after reset, then one upper-lane-only request.
        drive(2'b11, 2'b00, 0, 0, 1'b0, '0);
        chk("count_after_first_grant", longint'(free_count), 30);
        chk("offered_lane0", longint'(alloc_phys[0]), 34);
        chk("offered_lane1", longint'(alloc_phys[1]), 35);
        drive(2'b10, 2'b00, 0, 0, 1'b0, '0);

        // Random traffic with occasional checkpoint restores.
        for (int c = 0; c < 400; c++) begin
            fen = FW'($urandom_range(0, 3));
            f0  = pick_release();
            f1  = (($urandom % 6) == 0) ? f0 : pick_release();
            rm  = {$urandom, $urandom};
            drive(AW'($urandom_range(0, 3)), fen, f0, f1, (($urandom % 25) == 0), rm);
        end

        // Drain to one free preg, then the all-or-nothing refusal and a single grant.
        for (int c = 0; c < 64 && mcount() > 1; c++) drive(2'b11, 2'b00, 0, 0, 1'b0, '0);
        if (mcount() == 0) drive(2'b00, 2'b01, pick_release(), 0, 1'b0, '0);
        drive(2'b11, 2'b00, 0, 0, 1'b0, '0);
        drive(2'b01, 2'b00, 0, 0, 1'b0, '0);
        chk("count_drained", longint'(free_count), 0);

        // Release into an empty list: no bypass, preg 40 offered next cycle.
        drive(2'b01, 2'b01, 40, 0, 1'b0, '0);
        drive(2'b01, 2'b00, 0, 0, 1'b0, '0);

        // Mid-operation reset, then a release of a never-allocated reset mapping.
        alloc_req = 2'b11;
        free_en   = 2'b11;
        do_reset();
        drive(2'b00, 2'b01, 5, 0, 1'b0, '0);
        chk("err_release_reset_map", longint'(dbl_free_err), 1);
        chk("count_after_preg5", longint'(free_count), 33);
        drive(2'b00, 2'b00, 0, 0, 1'b0, '0);
        chk("err_pulse_clears", longint'(dbl_free_err), 0);

        // Allocate past 40, then release 40 on both lanes in one cycle.
        repeat (5) drive(2'b11, 2'b00, 0, 0, 1'b0, '0);
        drive(2'b00, 2'b11, 40, 40, 1'b0, '0);
        chk("err_same_preg_two_lanes", longint'(dbl_free_err), 1);

        // Restore with a simultaneous release and allocation request.
        do_reset();
        drive(2'b11, 2'b01, 7, 0, 1'b1, {32'hFFFF_FFFF, 32'h0});
        chk("count_after_restore", longint'(free_count), 33);
        drive(2'b01, 2'b00, 0, 0, 1'b0, '0);
        drive(2'b00, 2'b00, 0, 0, 1'b0, '0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", longint'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
